btn_sw_debounce: RTL and testbench
==================================

# btn_sw_debounce

Synchronises and debounces the 5 push-buttons and 16 slide switches before they reach the `Enter` input stage, and produces one-cycle press pulses for the buttons. Sits between the board pins and `Enter`. `BTN_db`/`SW_db` drive `Enter`'s `BTN`/`SW`. `BTN_pulse` goes to the I/O register logic for edge-triggered commands.

## Interface
- `TICK_DIV`, default 100000: clock cycles per sample tick (1 ms at 100 MHz). Must be ≥ 1; 1 means sample every cycle.
- `STABLE_TICKS`, default 10: consecutive differing samples needed to accept a new level. Must be ≥ 2.

Ports:
- `clk`, input, 1: single system clock.
- `rst`, input, 1: synchronous, active-high reset.
- `BTN`, input, 5: raw asynchronous buttons.
- `SW`, input, 16: raw asynchronous switches.
- `BTN_db`, output, 5: debounced buttons.
- `SW_db`, output, 16: debounced switches.
- `BTN_pulse`, output, 5: one-cycle pulse on each debounced button rising edge.

## Operation
- **Synchroniser.** Each of the 21 inputs passes through a 2-FF synchroniser (`s1` then `s2`). Only `s2` is used downstream.
- **Tick generator.** Counter `tdiv` runs 0…TICK_DIV−1 and wraps to 0. `tick` is 1 when `tdiv == TICK_DIV−1`. When TICK_DIV = 1, `tick` is constantly 1.
- **Per-bit filter** (state = `db`, `cnt`). Nothing changes when `tick` = 0. When `tick` = 1:
  - `s2 == db`: set `cnt` ← 0 (a glitch restarts the count).
  - `s2 != db` and `cnt == STABLE_TICKS−1`: set `db` ← `s2` and `cnt` ← 0.
  - otherwise: `cnt` ← `cnt` + 1.
- **Widths.** `cnt` is $clog2(STABLE_TICKS) bits and `tdiv` is $clog2(TICK_DIV) bits, minimum 1. Neither counter can overflow: `cnt` never exceeds STABLE_TICKS−1.
- **Press pulse.** The `BTN_pulse[i]` register is set to 1 on the edge where `db` goes 0→1; on every other edge it is 0. The pulse is high in the first cycle `BTN_db[i]` reads 1. A 1→0 transition gives no pulse.
- **Independence.** Bits are filtered independently. Several bits may change, or pulse, in the same cycle.
- **Reset** (at any time, including mid-count):
  - `s1`, `s2`, `db`, `cnt`, `tdiv` and the pulse registers all go to 0.
  - After reset, all outputs are 0.
  - An input held at 1 through reset is accepted as a normal change afterwards; for a button this produces one pulse.

## Timing
- All outputs are registered. Their reset value is 0.
- **Latency.** Suppose a raw level changes before clock edge 0 and then stays stable. `db` updates at edge T, where 2 + (STABLE_TICKS−1)·TICK_DIV ≤ T ≤ 1 + STABLE_TICKS·TICK_DIV. It never updates earlier.
- **Glitch rejection.** A change lasting fewer than STABLE_TICKS consecutive ticks (as seen at `s2`) never reaches `db`.
- **Pulse width.** `BTN_pulse` is exactly 1 cycle wide. A further pulse needs a full release (debounced 1→0) followed by a new press.

## Structure
- Package `io_pkg`: constants `NUM_BTN` = 5 and `NUM_SW` = 16.
- Sub-module `debounce_bit`, instantiated 21 times:
  - inputs: `clk`, `rst`, `tick`, raw `in`;
  - outputs: `db`, `rise`;
  - contains its own 2-FF synchroniser and `cnt`.
- Top-level `btn_sw_debounce` owns the single shared tick generator. It registers `BTN_pulse` from the `rise` outputs of the button instances.

## Test plan
All scenarios use TICK_DIV = 4 and STABLE_TICKS = 3.
- **Reset.** Assert `rst` for 3 cycles with `BTN` = 5'h1F and `SW` = 16'hFFFF → during reset all outputs are 0. After release, `SW_db` = 16'hFFFF at edge 10–13, and `BTN_db` = 5'h1F with `BTN_pulse` = 5'h1F for exactly 1 cycle.
- **Clean press.** `BTN[2]` goes 0→1 and is held → `BTN_db[2]` rises at edge 10–13 (not before edge 10). `BTN_pulse` = 5'b00100 for 1 cycle, then 0 while the button is still held.
- **Bounce.** `BTN[0]` toggles 1/0 every 3 cycles for 40 cycles, then stays 1 → `BTN_db[0]` stays 0 while bouncing. After the final level it rises within 13 cycles, with a single pulse.
- **Glitch.** `SW[7]` is high for 8 cycles then returns low → `SW_db[7]` stays 0 throughout and no other bit changes.
- **Simultaneous changes.** `SW` goes 16'h0000→16'hA5A5 in one cycle → `SW_db` becomes 16'hA5A5 in a single cycle. Release → no `BTN_pulse` on any bit.
- **Reset mid-count.** Assert `rst` for 1 cycle, 6 cycles after a `BTN[4]` press → `BTN_db[4]` stays 0. The full 10–13 cycle latency restarts from the reset release.

Source files
------------

// File: rtl/io_pkg.sv
// Shared board-I/O constants for the button/switch input path.
package io_pkg;

  localparam int NUM_BTN = 5;
  localparam int NUM_SW  = 16;

  // Counter width for a modulus n; never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/debounce_bit.sv
// One input bit: 2-FF synchroniser followed by a tick-driven stability filter.
// rise is combinational and marks the edge on which db is about to go 0->1.
module debounce_bit
  import io_pkg::*;
#(
  parameter int STABLE_TICKS = 10
) (
  input  logic clk,
  input  logic rst,
  input  logic tick,
  input  logic in,
  output logic db,
  output logic rise
);

  localparam int CNT_W = cnt_width(STABLE_TICKS);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_TICKS - 1);

  logic             s1_q;
  logic             s2_q;
  logic             db_q;
  logic             db_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Two-stage synchroniser for the asynchronous pin.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
    end else begin
      s1_q <= in;
      s2_q <= s1_q;
    end
  end

  // Filter next state: count consecutive differing ticks, accept on the last one.
  always_comb begin
    db_d  = db_q;
    cnt_d = cnt_q;
    if (tick) begin
      if (s2_q == db_q) begin
        cnt_d = '0;
      end else if (cnt_q == CNT_LAST) begin
        db_d  = s2_q;
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  // Filter state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      db_q  <= 1'b0;
      cnt_q <= '0;
    end else begin
      db_q  <= db_d;
      cnt_q <= cnt_d;
    end
  end

  assign db   = db_q;
  assign rise = db_d & ~db_q;

endmodule

// File: rtl/btn_sw_debounce.sv
// Synchronises and debounces the board buttons and switches, and turns each
// debounced button press into a one-cycle pulse. One tick generator is shared
// by all 21 filters so every bit samples on the same cycle.
module btn_sw_debounce
  import io_pkg::*;
#(
  parameter int TICK_DIV     = 100000,
  parameter int STABLE_TICKS = 10
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_BTN-1:0] BTN,
  input  logic [NUM_SW-1:0]  SW,
  output logic [NUM_BTN-1:0] BTN_db,
  output logic [NUM_SW-1:0]  SW_db,
  output logic [NUM_BTN-1:0] BTN_pulse
);

  localparam int TDIV_W = cnt_width(TICK_DIV);
  localparam logic [TDIV_W-1:0] TDIV_LAST = TDIV_W'(TICK_DIV - 1);

  logic [TDIV_W-1:0]  tdiv_q;
  logic [TDIV_W-1:0]  tdiv_d;
  logic               tick;
  logic [NUM_BTN-1:0] btn_rise;
  logic [NUM_SW-1:0]  sw_rise_unused;
  logic [NUM_BTN-1:0] pulse_q;

  // With TICK_DIV = 1 the counter is stuck at 0 == TDIV_LAST, so tick stays high.
  assign tick = (tdiv_q == TDIV_LAST);

  // Tick divider next state: wrap after TICK_DIV-1.
  always_comb begin
    tdiv_d = tdiv_q + TDIV_W'(1);
    if (tick) begin
      tdiv_d = '0;
    end
  end

  // Tick divider register.
  always_ff @(posedge clk) begin
    if (rst) begin
      tdiv_q <= '0;
    end else begin
      tdiv_q <= tdiv_d;
    end
  end

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
    debounce_bit #(.STABLE_TICKS(STABLE_TICKS)) u_db (
      .clk  (clk),
      .rst  (rst),
      .tick (tick),
      .in   (BTN[i]),
      .db   (BTN_db[i]),
      .rise (btn_rise[i])
    );
  end

  // Switches have no edge consumer; their rise outputs are left to trim away.
  for (genvar i = 0; i < NUM_SW; i++) begin : g_sw
    debounce_bit #(.STABLE_TICKS(STABLE_TICKS)) u_db (
      .clk  (clk),
      .rst  (rst),
      .tick (tick),
      .in   (SW[i]),
      .db   (SW_db[i]),
      .rise (sw_rise_unused[i])
    );
  end

  // Press pulse: registered on the same edge db goes high, so it lines up
  // with the first cycle BTN_db reads 1.
  always_ff @(posedge clk) begin
    if (rst) begin
      pulse_q <= '0;
    end else begin
      pulse_q <= btn_rise;
    end
  end

  assign BTN_pulse = pulse_q;

endmodule

// File: tb/tb_btn_sw_debounce.sv
// Directed bench for btn_sw_debounce with TICK_DIV = 4, STABLE_TICKS = 3.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_btn_sw_debounce;

  logic        clk;
  logic        rst;
  logic [4:0]  BTN;
  logic [15:0] SW;
  logic [4:0]  BTN_db;
  logic [15:0] SW_db;
  logic [4:0]  BTN_pulse;

  int n_vec;
  int n_err;
  logic [20:0] exp_q[$];

  btn_sw_debounce #(.TICK_DIV(4), .STABLE_TICKS(3)) dut (
    .clk       (clk),
    .rst       (rst),
    .BTN       (BTN),
    .SW        (SW),
    .BTN_db    (BTN_db),
    .SW_db     (SW_db),
    .BTN_pulse (BTN_pulse)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: expected {BTN_db, SW_db} values consumed in order.
  task automatic sb_expect(input logic [20:0] v);
    exp_q.push_back(v);
  endtask

  task automatic sb_check(input string tag);
    logic [20:0] e;
    if (exp_q.size() == 0) begin
      check_eq({tag, "_sb_empty"}, 32'd0, 32'd1);
    end else begin
      e = exp_q.pop_front();
      check_eq(tag, 32'({BTN_db, SW_db}), 32'(e));
    end
  endtask

  task automatic drive(input logic [4:0] b, input logic [15:0] s);
    BTN = b;
    SW  = s;
  endtask

  // Watch the debounced vector move from old_v to tgt. The change was applied
  // just before edge 0; n counts edges. Checks latency, that the vector only
  // ever holds old_v or tgt, and the pulse count/shape.
  task automatic watch(input string tag, input logic [20:0] old_v, input logic [20:0] tgt,
                       input logic [4:0] pulse_exp, input int lo, input int hi);
    int t;
    int np;
    int bad;
    logic [20:0] cur;
    t = -1;
    np = 0;
    bad = 0;
    for (int n = 0; n < 24; n++) begin
      @(negedge clk);
      cur = {BTN_db, SW_db};
      if (cur !== old_v && cur !== tgt) bad++;
      if (BTN_pulse !== 5'b0) np++;
      if (t < 0 && cur === tgt) begin
        t = n;
        check_eq({tag, "_pulse_at_first_db"}, 32'(BTN_pulse), 32'(pulse_exp));
      end
    end
    if (lo == hi) check_eq({tag, "_latency"}, 32'(t), 32'(lo));
    else          check_eq({tag, "_latency_in_range"}, 32'(t >= lo && t <= hi), 32'd1);
    check_eq({tag, "_intermediate_values"}, 32'(bad), 32'd0);
    check_eq({tag, "_pulse_cycles"}, 32'(np), (pulse_exp != 5'b0) ? 32'd1 : 32'd0);
    sb_expect(tgt);
    sb_check({tag, "_final"});
  endtask

  initial begin
    int bad;
    n_vec = 0;
    n_err = 0;
    rst = 1'b1;
    drive(5'h1F, 16'hFFFF);

    // Reset with all inputs high: outputs held at 0.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_eq("reset_btn_db", 32'(BTN_db), 32'd0);
      check_eq("reset_sw_db", 32'(SW_db), 32'd0);
      check_eq("reset_pulse", 32'(BTN_pulse), 32'd0);
    end
    rst = 1'b0;
    // Tick phase is known after reset: ticks at edges 3, 7, 11 -> db at 11.
    watch("reset_accept", 21'h0, 21'h1FFFFF, 5'h1F, 11, 11);

    drive(5'h00, 16'h0000);
    watch("reset_release", 21'h1FFFFF, 21'h0, 5'h00, 10, 13);

    // Clean press of BTN[2].
    drive(5'b00100, 16'h0000);
    watch("press_btn2", 21'h0, {5'b00100, 16'h0}, 5'b00100, 10, 13);
    drive(5'h00, 16'h0000);
    watch("release_btn2", {5'b00100, 16'h0}, 21'h0, 5'h00, 10, 13);

    // Bounce on BTN[0]: 3 cycles per level for 40 cycles.
    bad = 0;
    for (int i = 0; i < 40; i++) begin
      drive({4'b0, ((i / 3) % 2 == 0)}, 16'h0000);
      @(negedge clk);
      if ({BTN_db, SW_db} !== 21'h0 || BTN_pulse !== 5'b0) bad++;
    end
    check_eq("bounce_no_change", 32'(bad), 32'd0);
    drive(5'b00001, 16'h0000);
    watch("bounce_settle", 21'h0, {5'b00001, 16'h0}, 5'b00001, 0, 13);
    drive(5'h00, 16'h0000);
    watch("bounce_release", {5'b00001, 16'h0}, 21'h0, 5'h00, 10, 13);

    // Glitch on SW[7]: high for 8 cycles only.
    drive(5'h00, 16'h0080);
    for (int i = 0; i < 30; i++) begin
      if (i == 8) drive(5'h00, 16'h0000);
      @(negedge clk);
      sb_expect(21'h0);
      sb_check("glitch_sw7_outputs");
      check_eq("glitch_sw7_pulse", 32'(BTN_pulse), 32'd0);
    end

    // Many switches change together.
    drive(5'h00, 16'hA5A5);
    watch("sw_a5a5", 21'h0, {5'h0, 16'hA5A5}, 5'h00, 10, 13);
    drive(5'h00, 16'h0000);
    watch("sw_a5a5_release", {5'h0, 16'hA5A5}, 21'h0, 5'h00, 10, 13);

    // Reset in the middle of a BTN[4] count.
    drive(5'b10000, 16'h0000);
    for (int i = 0; i < 6; i++) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_eq("midreset_btn_db", 32'(BTN_db), 32'd0);
    rst = 1'b0;
    watch("midreset_press", 21'h0, {5'b10000, 16'h0}, 5'b10000, 11, 11);

    check_eq("sb_queue_drained", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
